// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, widths and arbiter state encoding
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int SHAMT_W   = 5;
    localparam int OP_W      = 4;

    localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [OP_W-1:0] ALU_NOT = 4'd2;
    localparam logic [OP_W-1:0] ALU_SLL = 4'd3;
    localparam logic [OP_W-1:0] ALU_SRL = 4'd4;
    localparam logic [OP_W-1:0] ALU_AND = 4'd5;
    localparam logic [OP_W-1:0] ALU_OR  = 4'd6;
    localparam logic [OP_W-1:0] ALU_SLT = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Codes 8..15 have no defined ALU behaviour.
    function automatic logic op_illegal(input logic [OP_W-1:0] op);
        return op[OP_W-1];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with a priority flop
module rr_arb2 #(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic prio;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = prio ? 2'b10 : 2'b01;
        end
    end

    // After an accept the port that was not served holds priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= PRIO_INIT;
        end else if (accept) begin
            prio <= grant[0];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one external combinational ALU between two requesters
import alu_pkg::*;

module alu_arbiter #(
    parameter int WIDTH     = 32,
    parameter int PRIO_INIT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic [OP_W-1:0]    req0_op,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    input  logic [OP_W-1:0]    req1_op,
    input  logic [SHAMT_W-1:0] req1_shamt,
    output logic               resp0_valid,
    input  logic               resp0_ready,
    output logic               resp1_valid,
    input  logic               resp1_ready,
    output logic [WIDTH-1:0]   resp_result,
    output logic               resp_zero,
    output logic               resp_err,
    output logic [WIDTH-1:0]   alu_input1,
    output logic [WIDTH-1:0]   alu_input2,
    output logic [OP_W-1:0]    alu_cnt,
    output logic [SHAMT_W-1:0] alu_shamt,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_zero
);

    arb_state_t         state, state_nx;
    logic               active;
    logic [1:0]         grant;
    logic               accept;
    logic               resp_fire;
    logic               owner;
    logic [WIDTH-1:0]   op_a, op_b;
    logic [OP_W-1:0]    op_cnt;
    logic [SHAMT_W-1:0] op_shamt;

    rr_arb2 #(
        .PRIO_INIT (PRIO_INIT != 0)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1_valid, req0_valid}),
        .accept (accept),
        .grant  (grant)
    );

    // Keeps the request ready outputs low while reset is held, even in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    assign req0_ready  = active && (state == IDLE) && grant[0];
    assign req1_ready  = active && (state == IDLE) && grant[1];
    assign accept      = req0_ready || req1_ready;
    assign resp0_valid = (state == RESP) && !owner;
    assign resp1_valid = (state == RESP) &&  owner;
    assign resp_fire   = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (resp_fire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_cnt   <= '0;
            op_shamt <= '0;
        end else if (accept) begin
            owner    <= grant[1];
            op_a     <= grant[1] ? req1_a     : req0_a;
            op_b     <= grant[1] ? req1_b     : req0_b;
            op_cnt   <= grant[1] ? req1_op    : req0_op;
            op_shamt <= grant[1] ? req1_shamt : req0_shamt;
        end
    end

    assign alu_input1 = op_a;
    assign alu_input2 = op_b;
    assign alu_cnt    = op_cnt;
    assign alu_shamt  = op_shamt;

    // Illegal ops ignore whatever the ALU produced and report a zero result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp_err    <= 1'b0;
        end else if (state == EXEC) begin
            resp_result <= op_illegal(op_cnt) ? '0 : alu_result;
            resp_zero   <= op_illegal(op_cnt) ? 1'b1 : alu_zero;
            resp_err    <= op_illegal(op_cnt);
        end
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. port 0 = main EX stage and port 1 = branch/address helper.
- Per-port valid/ready request and response handshakes.
- Round-robin grant; one transaction in flight.
- Drives the ALU operand/control inputs from registered operands and captures result/zero into a response register.

Parameters:
- WIDTH, 32, operand/result width (ALU is fixed 32-bit; other values unsupported).
- PRIO_INIT, 0, port that holds priority after reset (0 or 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle when valid&&ready
- req0_a  in  WIDTH  port 0 operand 1
- req0_b  in  WIDTH  port 0 operand 2
- req0_op  in  4  port 0 ALU control code
- req0_shamt  in  5  port 0 shift amount
- req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_shamt: same as port 0, for port 1
- resp0_valid  out  1  port 0 response valid
- resp0_ready  in  1  port 0 consumer accepts response
- resp1_valid  out  1  port 1 response valid
- resp1_ready  in  1  port 1 consumer accepts response
- resp_result  out  WIDTH  response result, shared by both ports
- resp_zero  out  1  response zero flag
- resp_err  out  1  illegal op code (8..15)
- alu_input1  out  WIDTH  to ALU
- alu_input2  out  WIDTH  to ALU
- alu_cnt  out  4  to ALU
- alu_shamt  out  5  to ALU
- alu_result  in  WIDTH  from ALU
- alu_zero  in  1  from ALU

Behaviour:
- FSM states:
  - IDLE: reqN_ready is combinational; only the granted port sees ready=1, and only in IDLE.
  - EXEC: one cycle. ALU inputs come from operand registers; result and zero are captured at the end of EXEC.
  - RESP: respN_valid=1 for the owner until respN_ready.
  - Transitions:
    - IDLE->EXEC on an accepted request.
    - EXEC->RESP always.
    - RESP->IDLE when the owner's resp_ready=1.
- Grant in IDLE:
  - One valid request: that port is granted.
  - Both valid: the priority port is granted.
  - After every accept, priority moves to the other port.
  - Priority is unchanged when nothing is accepted.
- Latency and throughput:
  - Request accepted at edge N; respN_valid high from cycle N+2.
  - Earliest next accept is the cycle after the response handshake.
  - Max throughput is 1 op per 3 cycles.
- Operand capture:
  - Operands, op, shamt and owner are registered on accept.
  - Requesters may change inputs after the accept edge.
- ALU drive:
  - alu_input1/2, alu_cnt and alu_shamt always come from the operand registers.
  - They are never floating; all zeros after reset.
- Illegal op (op >= 8, where the ALU output is undefined):
  - alu_cnt is still driven with the op.
  - Captured result is forced to 0, resp_zero=1, resp_err=1.
  - For legal ops resp_err=0.
- Response outputs:
  - resp_result, resp_zero and resp_err hold stable while a response is pending.
  - They are don't-care outside RESP but are kept at their last values.
- Pending response:
  - respN_valid of the non-owner is 0.
  - Owner's valid stays high indefinitely until ready; reqX_ready=0 on both ports meanwhile.
- resp_ready arriving in IDLE or EXEC is ignored.
- Reset (async, any state, including mid-EXEC or mid-RESP):
  - State=IDLE, priority=PRIO_INIT.
  - All ready/valid outputs 0; resp_result=0, resp_zero=0, resp_err=0; operand registers 0.
  - An in-flight transaction is dropped with no response.

Decomposition:
- Shared package alu_pkg holds:
  - ALU op constants: ADD=0, SUB=1, NOT=2, SLL=3, SRL=4, AND=5, OR=6, SLT=7.
  - ALU_WIDTH=32, SHAMT_W=5.
  - State encoding IDLE/EXEC/RESP.
- One natural sub-module: rr_arb2, a 2-way round-robin grant with a priority flop.
- The ALU stays instantiated outside this block.

Test Plan:
- Single request, port 0: ADD a=5, b=7 at edge N -> resp0_valid at N+2, result=12, zero=0, err=0; req0_ready=0 until the handshake completes.
- Simultaneous requests after reset (PRIO_INIT=0): port 0 SUB 9-9, port 1 OR 0xF0|0x0F.
  - Port 0 served first: result 0, zero=1.
  - Then port 1: result 0xFF.
  - Next simultaneous pair is granted to port 0 again.
- Backpressure: port 1 SLL a=1, shamt=4 with resp1_ready held 0 for 5 cycles -> resp1_valid and result=16 stable throughout; req0_valid=1 sees req0_ready=0 until the handshake.
- Illegal op 4'b1010 on port 0 -> result=0, zero=1, err=1; the next legal SLT 3<4 -> result=1, err=0.
- Async reset asserted mid-EXEC and mid-RESP -> all outputs 0 immediately without a clock edge; no response after release; first grant follows PRIO_INIT.
- Operand change after accept: req0_a altered the cycle after accept -> result reflects the captured value (NOT 0 -> 0xFFFFFFFF).
